// File: rtl/stack_cpu_core.sv
// rtl/stack_cpu_core.sv - multicycle 8-bit stack CPU: controller FSM, 32x8 memory, 8-deep operand stack, ALU
module stack_cpu_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       prog_we,
    input  logic [4:0] prog_addr,
    input  logic [7:0] prog_data,
    input  logic [4:0] dbg_addr,
    output logic [7:0] dbg_data,
    output logic [4:0] pc,
    output logic [7:0] tos,
    output logic [3:0] depth,
    output logic       stack_full,
    output logic       stack_empty
);

    typedef enum logic [2:0] {
        S_FETCH, S_DECODE, S_LD, S_POP1, S_POP2, S_EXEC, S_PUSHS, S_ST
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_NOT  = 3'b011;
    localparam logic [2:0] OP_PUSH = 3'b100;
    localparam logic [2:0] OP_POP  = 3'b101;
    localparam logic [2:0] OP_JMP  = 3'b110;
    localparam logic [2:0] OP_JZ   = 3'b111;

    state_t     state, state_nx;
    logic [7:0] mem [32];
    logic [7:0] stk [8];
    logic [7:0] ir, a, b, mdr;
    logic [3:0] sp;
    logic [2:0] opcode;
    logic [4:0] addr;
    logic [2:0] top_idx;
    logic [7:0] pop_val, alu_out, push_data;

    logic ir_ld, pc_inc, pc_jump, mdr_ld, a_ld, b_ld, push, pop, mem_we, push_alu;

    assign opcode      = ir[7:5];
    assign addr        = ir[4:0];
    assign top_idx     = sp[2:0] - 3'd1;
    assign pop_val     = (sp == 4'd0) ? 8'h00 : stk[top_idx];
    assign push_data   = push_alu ? alu_out : mdr;
    assign dbg_data    = mem[dbg_addr];
    assign tos         = pop_val;
    assign depth       = sp;
    assign stack_full  = (sp == 4'd8);
    assign stack_empty = (sp == 4'd0);

    // ALU: B is the entry below the old top, A the old top
    always_comb begin
        alu_out = 8'h00;
        case (opcode)
            OP_ADD:  alu_out = b + a;
            OP_SUB:  alu_out = b - a;
            OP_AND:  alu_out = b & a;
            OP_NOT:  alu_out = ~a;
            default: alu_out = 8'h00;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_FETCH;
        else      state <= state_nx;
    end

    // Next-state logic
    always_comb begin
        state_nx = S_FETCH;
        case (state)
            S_FETCH:  state_nx = S_DECODE;
            S_DECODE: begin
                if (opcode == OP_JMP || opcode == OP_JZ) state_nx = S_FETCH;
                else if (opcode == OP_PUSH)              state_nx = S_LD;
                else                                     state_nx = S_POP1;
            end
            S_LD:     state_nx = S_PUSHS;
            S_POP1: begin
                if (opcode == OP_POP)      state_nx = S_ST;
                else if (opcode == OP_NOT) state_nx = S_EXEC;
                else                       state_nx = S_POP2;
            end
            S_POP2:   state_nx = S_EXEC;
            default:  state_nx = S_FETCH;
        endcase
    end

    // Control outputs decoded from the current state
    always_comb begin
        ir_ld    = 1'b0;
        pc_inc   = 1'b0;
        pc_jump  = 1'b0;
        mdr_ld   = 1'b0;
        a_ld     = 1'b0;
        b_ld     = 1'b0;
        push     = 1'b0;
        pop      = 1'b0;
        mem_we   = 1'b0;
        push_alu = 1'b0;
        case (state)
            S_FETCH:  begin ir_ld = 1'b1; pc_inc = 1'b1; end
            S_DECODE: pc_jump = (opcode == OP_JMP) || (opcode == OP_JZ && pop_val == 8'h00);
            S_LD:     mdr_ld = 1'b1;
            S_POP1:   begin a_ld = 1'b1; pop = 1'b1; end
            S_POP2:   begin b_ld = 1'b1; pop = 1'b1; end
            S_EXEC:   begin push = 1'b1; push_alu = 1'b1; end
            S_PUSHS:  push = 1'b1;
            S_ST:     mem_we = 1'b1;
            default:  ;
        endcase
    end

    // PC, IR, operand registers and stack depth
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc  <= 5'd0;
            ir  <= 8'h00;
            a   <= 8'h00;
            b   <= 8'h00;
            mdr <= 8'h00;
            sp  <= 4'd0;
        end else begin
            if (ir_ld)   ir  <= mem[pc];
            if (pc_inc)  pc  <= pc + 5'd1;
            if (pc_jump) pc  <= addr;
            if (mdr_ld)  mdr <= mem[addr];
            if (a_ld)    a   <= pop_val;
            if (b_ld)    b   <= pop_val;
            if (push && !stack_full)      sp <= sp + 4'd1;
            else if (pop && !stack_empty) sp <= sp - 4'd1;
        end
    end

    // Stack storage; a push onto a full stack is dropped
    always_ff @(posedge clk) begin
        if (push && !stack_full) stk[sp[2:0]] <= push_data;
    end

    // Memory writes: program load while held in reset, ST while running
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (prog_we) mem[prog_addr] <= prog_data;
        end else if (mem_we) begin
            mem[addr] <= a;
        end
    end

endmodule

// File: tb/tb_stack_cpu_core.sv
// tb/tb_stack_cpu_core.sv - directed scoreboard bench for stack_cpu_core
module tb_stack_cpu_core;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       prog_we = 1'b0;
    logic [4:0] prog_addr = 5'd0;
    logic [7:0] prog_data = 8'h00;
    logic [4:0] dbg_addr = 5'd0;
    logic [7:0] dbg_data;
    logic [4:0] pc;
    logic [7:0] tos;
    logic [3:0] depth;
    logic       stack_full;
    logic       stack_empty;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    exp_t sb[$];

    stack_cpu_core dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .pc(pc), .tos(tos), .depth(depth), .stack_full(stack_full),
        .stack_empty(stack_empty)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ld(input logic [4:0] ad, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = ad;
        prog_data = d;
        tick(1);
        prog_we   = 1'b0;
    endtask

    task automatic want(input string t, input logic [31:0] v);
        sb.push_back('{t, v});
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_underflow: got %0h expected nothing", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                miscompares++;
                $error("FAIL %s: got %0h expected %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic chk_mem(input logic [4:0] ad);
        dbg_addr = ad;
        #1;
        chk({24'd0, dbg_data});
    endtask

    initial begin
        // Reset state and program load during reset
        want("rst_pc", 0); want("rst_depth", 0); want("rst_tos", 0);
        want("rst_empty", 1); want("rst_full", 0);
        tick(2);
        chk(pc); chk(depth); chk(tos); chk(stack_empty); chk(stack_full);
        ld(5'd5, 8'hAA);
        want("load_mem5", 8'hAA);
        chk_mem(5'd5);

        // ADD program: mem[22] = 5 + 3
        ld(5'd0, 8'h94); ld(5'd1, 8'h95); ld(5'd2, 8'h00); ld(5'd3, 8'hB6);
        ld(5'd4, 8'hC4); ld(5'd20, 8'd5); ld(5'd21, 8'd3); ld(5'd25, 8'h11);
        want("add_push_depth", 1); want("add_push_tos", 5);
        want("add_mem22", 8); want("add_depth", 0);
        want("jmp_pc5", 5); want("jmp_pc4", 4); want("jmp_pc5b", 5);
        want("prog_we_ignored", 8'h11);
        rst = 1'b1;
        tick(4);
        chk(depth); chk(tos);
        tick(13);
        chk_mem(5'd22); chk(depth);
        tick(1); chk(pc);
        tick(1); chk(pc);
        tick(1); chk(pc);
        prog_we = 1'b1; prog_addr = 5'd25; prog_data = 8'h55;
        tick(1);
        prog_we = 1'b0;
        chk_mem(5'd25);

        // SUB: 7 - 3
        rst = 1'b0;
        ld(5'd0, 8'h94); ld(5'd1, 8'h95); ld(5'd2, 8'h20); ld(5'd3, 8'hC3);
        ld(5'd20, 8'd7); ld(5'd21, 8'd3);
        want("sub_tos", 4); want("sub_depth", 1);
        rst = 1'b1;
        tick(13);
        chk(tos); chk(depth);

        // AND: 0x3C & 0x0F
        rst = 1'b0;
        ld(5'd2, 8'h40); ld(5'd20, 8'h3C); ld(5'd21, 8'h0F);
        want("and_tos", 8'h0C); want("and_depth", 1);
        rst = 1'b1;
        tick(13);
        chk(tos); chk(depth);

        // NOT of 0x0F
        rst = 1'b0;
        ld(5'd0, 8'h95); ld(5'd1, 8'h60); ld(5'd2, 8'hC2);
        want("not_tos", 8'hF0); want("not_depth", 1);
        rst = 1'b1;
        tick(8);
        chk(tos); chk(depth);

        // JZ taken on a zero top, stack not popped
        rst = 1'b0;
        ld(5'd0, 8'h94); ld(5'd1, 8'hEA); ld(5'd20, 8'd0); ld(5'd10, 8'hCA);
        want("jz_taken_pc", 10); want("jz_taken_depth", 1);
        rst = 1'b1;
        tick(6);
        chk(pc); chk(depth);

        // JZ falls through on a non-zero top
        rst = 1'b0;
        ld(5'd20, 8'd1);
        want("jz_fall_pc", 2); want("jz_fall_depth", 1);
        rst = 1'b1;
        tick(6);
        chk(pc); chk(depth);

        // JZ on the empty stack is taken
        rst = 1'b0;
        ld(5'd0, 8'hEA);
        want("jz_empty_pc", 10); want("jz_empty_depth", 0);
        rst = 1'b1;
        tick(2);
        chk(pc); chk(depth);

        // Stack bounds: nine pushes then nine pops
        rst = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ld(5'(i), 8'(8'h94 + i));
            ld(5'(20 + i), 8'(i + 1));
            ld(5'(9 + i), 8'(8'hB4 + i));
        end
        ld(5'd18, 8'hD2);
        for (int i = 1; i <= 9; i++) want("push_depth", (i > 8) ? 8 : i);
        want("full_tos", 8); want("full_flag", 1);
        want("drain_depth", 0); want("drain_empty", 1);
        for (int i = 20; i <= 27; i++) want("pop_mem", 28 - i);
        want("pop_empty_mem28", 0);
        rst = 1'b1;
        for (int i = 1; i <= 9; i++) begin
            tick(4);
            chk(depth);
        end
        chk(tos); chk(stack_full);
        tick(36);
        chk(depth); chk(stack_empty);
        for (int i = 20; i <= 28; i++) chk_mem(5'(i));

        // PC wrap from 31 to 0
        rst = 1'b0;
        ld(5'd0, 8'hDF); ld(5'd31, 8'h94); ld(5'd20, 8'h77);
        want("wrap_pc31", 31); want("wrap_pc0", 0);
        want("wrap_depth", 1); want("wrap_tos", 8'h77); want("wrap_pc1", 1);
        rst = 1'b1;
        tick(2); chk(pc);
        tick(1); chk(pc);
        tick(3); chk(depth); chk(tos);
        tick(1); chk(pc);

        // Reset asserted while ADD is in EXEC
        rst = 1'b0;
        ld(5'd0, 8'h94); ld(5'd1, 8'h95); ld(5'd2, 8'h00); ld(5'd3, 8'hC3);
        ld(5'd20, 8'd5); ld(5'd21, 8'd3);
        want("pre_exec_depth", 0);
        want("abort_pc", 0); want("abort_depth", 0); want("abort_tos", 0);
        want("abort_hold_depth", 0);
        rst = 1'b1;
        tick(12);
        chk(depth);
        rst = 1'b0;
        #1;
        chk(pc); chk(depth); chk(tos);
        tick(2);
        chk(depth);

        if (sb.size() != 0) begin
            miscompares++;
            $error("FAIL scoreboard_leftover: got %0d entries expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stack_cpu_core.md
# stack_cpu_core

Multicycle 8-bit zero-address (stack) processor: controller FSM plus datapath with a 32×8 unified instruction/data memory, an 8-entry hardware operand stack, an ALU and PC/IR/operand registers. It is the complete CPU of the stack-machine design. A thin top level provides the clock and reset, and a program-load port lets the bench place code and data in memory. Three debug outputs give observability: the PC, the top of stack (TOS) and a memory read port.

## Interface
- No parameters. Fixed sizes: data width 8, address width 5, stack depth 8.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- prog_we  in  1  memory load strobe; honoured only while rst is low.
- prog_addr  in  5  load address.
- prog_data  in  8  load data.
- dbg_addr  in  5  debug read address.
- dbg_data  out  8  mem[dbg_addr], combinational.
- pc  out  5  current program counter.
- tos  out  8  top-of-stack value; 0 when the stack is empty.
- depth  out  4  number of stack entries, 0..8.
- stack_full  out  1  depth == 8.
- stack_empty  out  1  depth == 0.

## Operation
- Instruction format: opcode = [7:5], addr = [4:0].
- Opcodes:
  - 000 ADD
  - 001 SUB
  - 010 AND
  - 011 NOT
  - 100 PUSH addr
  - 101 POP addr
  - 110 JMP addr
  - 111 JZ addr
- Memory: asynchronous read; synchronous write. Reset does not clear memory.
- Stack:
  - push writes entry[depth] and increments depth.
  - pop returns entry[depth-1] and decrements depth.
  - Push when full is ignored: depth and contents unchanged.
  - Pop when empty returns 0; depth stays 0.
- Controller FSM states:
  - FETCH: IR ← mem[PC]; PC ← PC+1 (5-bit wrap 31→0); go to DECODE.
  - DECODE:
    - JMP: PC ← addr; go to FETCH.
    - JZ: if TOS == 0 (including the empty stack), PC ← addr; go to FETCH. JZ never pops.
    - PUSH: go to LD.
    - POP, ALU ops, NOT: go to POP1.
  - LD: MDR ← mem[addr]; go to PUSHS.
  - POP1: A ← pop.
    - POP: go to ST.
    - NOT: go to EXEC.
    - ADD/SUB/AND: go to POP2.
  - POP2: B ← pop; go to EXEC.
  - EXEC: push ALU result; go to FETCH.
    - ADD: B+A, modulo 256.
    - SUB: B−A, modulo 256.
    - AND: B&A.
    - NOT: ~A.
  - PUSHS: push MDR; go to FETCH.
  - ST: mem[addr] ← A; go to FETCH.
- Operand order: A is the old top, B the next entry. SUB computes next − top. No carry or overflow flags.
- Program load: while rst is low, each rising clk with prog_we=1 writes prog_data to mem[prog_addr]. prog_we is ignored while rst is high.

## Timing
- Reset (async, rst low) forces:
  - PC=0, IR=0, A=B=MDR=0, state=FETCH, depth=0.
  - Outputs: pc=0, tos=0, depth=0, stack_empty=1, stack_full=0.
  - Memory is retained.
- After rst goes high, the first rising edge performs FETCH of mem[0].
- Cycles per instruction:
  - JMP, JZ: 2.
  - PUSH: 4.
  - POP: 4.
  - NOT: 4.
  - ADD, SUB, AND: 5.
- A stack write occurs only in PUSHS and EXEC, so depth never changes by more than 1 per cycle.
- pc, tos, depth and the flags are registered-state views. They update on the edge that changes the underlying state.
- Reset asserted mid-instruction aborts the instruction immediately. A memory write is not performed unless its ST edge has already occurred.
- dbg_data follows dbg_addr combinationally and reflects a ST write right after that edge.

## Test plan
- Reset check: hold rst low 2 cycles → pc=0, depth=0, tos=0, stack_empty=1. Load mem[5]=0xAA during reset → dbg_data=0xAA with dbg_addr=5.
- ADD program:
  - Load mem[0..4] = 0x94, 0x95, 0x00, 0xB6, 0xC4 and mem[20]=5, mem[21]=3.
  - Release reset → after 17 cycles mem[22]=8, depth=0.
  - Then the JMP at address 4 loops every 2 cycles; pc alternates 5/4.
- SUB/AND/NOT:
  - mem[20]=7, mem[21]=3: PUSH 20, PUSH 21, SUB → tos=4, depth=1.
  - Repeat with AND, operands 0x3C and 0x0F → tos=0x0C.
  - PUSH of 0x0F, then NOT → tos=0xF0.
- JZ:
  - PUSH of a 0 word, then JZ 10 → pc=10 on the next FETCH, depth still 1.
  - With TOS=1 → falls through to the next address.
  - JZ on the empty stack → taken.
- Stack bounds:
  - Nine PUSHes of values 1..9 → depth=8, tos=8, stack_full=1.
  - Nine POPs to addrs 20..28 → mem[20..27]=8..1, mem[28]=0, depth=0.
- Wrap/reset: an instruction at 31 fetches next from 0. Asserting rst during EXEC of ADD → depth=0, pc=0, no push.
